// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS core: ALU/shift/immediate datapath, an
// iterative shift-add multiplier that stalls the front end, and the EX/MEM register.
module ex_stage #(
    parameter int BITS_PER_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ID_EX_A,
    input  logic [31:0] ID_EX_B,
    input  logic [4:0]  ID_EX_rt,
    input  logic [4:0]  ID_EX_rs,
    input  logic [4:0]  ID_EX_rd,
    input  logic [5:0]  ID_EX_opcode,
    input  logic [31:0] ID_EX_sign_extend_offset,
    input  logic        ID_EX_wb_reg_write,
    input  logic        ID_EX_wb_mem_to_reg,
    input  logic        ID_EX_mem_read,
    input  logic        ID_EX_mem_write,
    input  logic        ID_EX_ex_imm_command,
    input  logic        ID_EX_ex_alu_src_b,
    input  logic        ID_EX_ex_alu_rslt_src,
    input  logic [1:0]  ID_EX_ex_dst_reg_sel,
    input  logic [1:0]  ID_EX_ex_alu_op,
    output logic [31:0] EX_MEM_alu_result,
    output logic [31:0] EX_MEM_B,
    output logic [4:0]  EX_MEM_dst_reg,
    output logic        EX_MEM_wb_reg_write,
    output logic        EX_MEM_wb_mem_to_reg,
    output logic        EX_MEM_mem_read,
    output logic        EX_MEM_mem_write,
    output logic [4:0]  ex_dst_reg,
    output logic        pstop_o
);

    localparam int         N        = 32 / BITS_PER_STEP;
    localparam logic [4:0] LAST_CNT = 5'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

    mul_state_t  state;
    mul_state_t  state_next;

    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] imm_val;
    logic [31:0] op_b;
    logic        signed_lt;
    logic        unsigned_lt;
    logic [31:0] alu_val;
    logic [31:0] result;
    logic        mul_present;

    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [31:0] partial;
    logic [4:0]  cnt;

    logic        unused_rs;

    // rs is only consumed by the hazard unit upstream.
    assign unused_rs = ^ID_EX_rs;

    assign funct   = ID_EX_sign_extend_offset[5:0];
    assign shamt   = ID_EX_sign_extend_offset[10:6];
    assign imm_val = ID_EX_ex_imm_command ? {16'h0000, ID_EX_sign_extend_offset[15:0]}
                                          : ID_EX_sign_extend_offset;
    assign op_b    = ID_EX_ex_alu_src_b ? imm_val : ID_EX_B;

    assign signed_lt   = $signed(ID_EX_A) < $signed(op_b);
    assign unsigned_lt = ID_EX_A < op_b;

    always_comb begin
        alu_val = '0;
        case (ID_EX_ex_alu_op)
            2'b00: alu_val = ID_EX_A + op_b;
            2'b01: alu_val = ID_EX_A - op_b;
            2'b10: begin
                case (funct)
                    6'h20, 6'h21: alu_val = ID_EX_A + op_b;
                    6'h22, 6'h23: alu_val = ID_EX_A - op_b;
                    6'h24:        alu_val = ID_EX_A & op_b;
                    6'h25:        alu_val = ID_EX_A | op_b;
                    6'h26:        alu_val = ID_EX_A ^ op_b;
                    6'h27:        alu_val = ~(ID_EX_A | op_b);
                    6'h2A:        alu_val = {31'b0, signed_lt};
                    6'h2B:        alu_val = {31'b0, unsigned_lt};
                    6'h00:        alu_val = op_b << shamt;
                    6'h02:        alu_val = op_b >> shamt;
                    6'h03:        alu_val = $signed(op_b) >>> shamt;
                    default:      alu_val = '0;
                endcase
            end
            default: begin
                case (ID_EX_opcode)
                    6'h0A:   alu_val = {31'b0, signed_lt};
                    6'h0B:   alu_val = {31'b0, unsigned_lt};
                    6'h0C:   alu_val = ID_EX_A & op_b;
                    6'h0D:   alu_val = ID_EX_A | op_b;
                    6'h0E:   alu_val = ID_EX_A ^ op_b;
                    6'h0F:   alu_val = {ID_EX_sign_extend_offset[15:0], 16'h0000};
                    default: alu_val = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        ex_dst_reg = '0;
        case (ID_EX_ex_dst_reg_sel)
            2'b00:   ex_dst_reg = ID_EX_rt;
            2'b01:   ex_dst_reg = ID_EX_rd;
            2'b10:   ex_dst_reg = 5'd31;
            default: ex_dst_reg = 5'd0;
        endcase
    end

    assign mul_present = ID_EX_ex_alu_rslt_src & ID_EX_wb_reg_write;
    assign pstop_o     = rst_n & mul_present & (state != DONE);
    assign result      = ID_EX_ex_alu_rslt_src ? acc : alu_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_present) state_next = BUSY;
            BUSY:    if (cnt == LAST_CNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Partial product for the low BITS_PER_STEP multiplier bits, as a shift-add.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_STEP; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_present) begin
                        mcand  <= ID_EX_A;
                        mplier <= ID_EX_B;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << BITS_PER_STEP;
                    mplier <= mplier >> BITS_PER_STEP;
                    cnt    <= cnt + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // A stall turns the captured instruction into a bubble; data fields just hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EX_MEM_alu_result    <= '0;
            EX_MEM_B             <= '0;
            EX_MEM_dst_reg       <= '0;
            EX_MEM_wb_reg_write  <= 1'b0;
            EX_MEM_wb_mem_to_reg <= 1'b0;
            EX_MEM_mem_read      <= 1'b0;
            EX_MEM_mem_write     <= 1'b0;
        end else if (pstop_o) begin
            EX_MEM_wb_reg_write  <= 1'b0;
            EX_MEM_wb_mem_to_reg <= 1'b0;
            EX_MEM_mem_read      <= 1'b0;
            EX_MEM_mem_write     <= 1'b0;
        end else begin
            EX_MEM_alu_result    <= result;
            EX_MEM_B             <= ID_EX_B;
            EX_MEM_dst_reg       <= ex_dst_reg;
            EX_MEM_wb_reg_write  <= ID_EX_wb_reg_write;
            EX_MEM_wb_mem_to_reg <= ID_EX_wb_mem_to_reg;
            EX_MEM_mem_read      <= ID_EX_mem_read;
            EX_MEM_mem_write     <= ID_EX_mem_write;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: expected EX/MEM contents are queued as each instruction
// is driven and popped when the pipeline register captures it.
module tb_ex_stage;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] b;
        logic [4:0]  dst;
        logic [3:0]  ctrl;
    } exmem_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_n4;
    logic [31:0] ID_EX_A;
    logic [31:0] ID_EX_B;
    logic [4:0]  ID_EX_rt;
    logic [4:0]  ID_EX_rs;
    logic [4:0]  ID_EX_rd;
    logic [5:0]  ID_EX_opcode;
    logic [31:0] ID_EX_sign_extend_offset;
    logic        ID_EX_wb_reg_write;
    logic        ID_EX_wb_mem_to_reg;
    logic        ID_EX_mem_read;
    logic        ID_EX_mem_write;
    logic        ID_EX_ex_imm_command;
    logic        ID_EX_ex_alu_src_b;
    logic        ID_EX_ex_alu_rslt_src;
    logic [1:0]  ID_EX_ex_dst_reg_sel;
    logic [1:0]  ID_EX_ex_alu_op;

    logic [31:0] EX_MEM_alu_result, EX_MEM_B;
    logic [4:0]  EX_MEM_dst_reg, ex_dst_reg;
    logic        EX_MEM_wb_reg_write, EX_MEM_wb_mem_to_reg, EX_MEM_mem_read, EX_MEM_mem_write;
    logic        pstop_o;

    logic [31:0] EX_MEM_alu_result4, EX_MEM_B4;
    logic [4:0]  EX_MEM_dst_reg4, ex_dst_reg4;
    logic        EX_MEM_wb_reg_write4, EX_MEM_wb_mem_to_reg4, EX_MEM_mem_read4, EX_MEM_mem_write4;
    logic        pstop4;

    int          checks = 0;
    int          errors = 0;
    exmem_t      sb[$];
    string       sb_name[$];

    ex_stage #(.BITS_PER_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B),
        .ID_EX_rt(ID_EX_rt), .ID_EX_rs(ID_EX_rs), .ID_EX_rd(ID_EX_rd),
        .ID_EX_opcode(ID_EX_opcode), .ID_EX_sign_extend_offset(ID_EX_sign_extend_offset),
        .ID_EX_wb_reg_write(ID_EX_wb_reg_write), .ID_EX_wb_mem_to_reg(ID_EX_wb_mem_to_reg),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mem_write(ID_EX_mem_write),
        .ID_EX_ex_imm_command(ID_EX_ex_imm_command), .ID_EX_ex_alu_src_b(ID_EX_ex_alu_src_b),
        .ID_EX_ex_alu_rslt_src(ID_EX_ex_alu_rslt_src), .ID_EX_ex_dst_reg_sel(ID_EX_ex_dst_reg_sel),
        .ID_EX_ex_alu_op(ID_EX_ex_alu_op),
        .EX_MEM_alu_result(EX_MEM_alu_result), .EX_MEM_B(EX_MEM_B), .EX_MEM_dst_reg(EX_MEM_dst_reg),
        .EX_MEM_wb_reg_write(EX_MEM_wb_reg_write), .EX_MEM_wb_mem_to_reg(EX_MEM_wb_mem_to_reg),
        .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_mem_write(EX_MEM_mem_write),
        .ex_dst_reg(ex_dst_reg), .pstop_o(pstop_o)
    );

    ex_stage #(.BITS_PER_STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n4),
        .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B),
        .ID_EX_rt(ID_EX_rt), .ID_EX_rs(ID_EX_rs), .ID_EX_rd(ID_EX_rd),
        .ID_EX_opcode(ID_EX_opcode), .ID_EX_sign_extend_offset(ID_EX_sign_extend_offset),
        .ID_EX_wb_reg_write(ID_EX_wb_reg_write), .ID_EX_wb_mem_to_reg(ID_EX_wb_mem_to_reg),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mem_write(ID_EX_mem_write),
        .ID_EX_ex_imm_command(ID_EX_ex_imm_command), .ID_EX_ex_alu_src_b(ID_EX_ex_alu_src_b),
        .ID_EX_ex_alu_rslt_src(ID_EX_ex_alu_rslt_src), .ID_EX_ex_dst_reg_sel(ID_EX_ex_dst_reg_sel),
        .ID_EX_ex_alu_op(ID_EX_ex_alu_op),
        .EX_MEM_alu_result(EX_MEM_alu_result4), .EX_MEM_B(EX_MEM_B4), .EX_MEM_dst_reg(EX_MEM_dst_reg4),
        .EX_MEM_wb_reg_write(EX_MEM_wb_reg_write4), .EX_MEM_wb_mem_to_reg(EX_MEM_wb_mem_to_reg4),
        .EX_MEM_mem_read(EX_MEM_mem_read4), .EX_MEM_mem_write(EX_MEM_mem_write4),
        .ex_dst_reg(ex_dst_reg4), .pstop_o(pstop4)
    );

    always #5 clk = ~clk;

    function automatic exmem_t exmem1();
        return {EX_MEM_alu_result, EX_MEM_B, EX_MEM_dst_reg,
                EX_MEM_wb_reg_write, EX_MEM_wb_mem_to_reg, EX_MEM_mem_read, EX_MEM_mem_write};
    endfunction

    function automatic exmem_t exmem4();
        return {EX_MEM_alu_result4, EX_MEM_B4, EX_MEM_dst_reg4,
                EX_MEM_wb_reg_write4, EX_MEM_wb_mem_to_reg4, EX_MEM_mem_read4, EX_MEM_mem_write4};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] r, input logic [31:0] b, input logic [4:0] d,
                            input logic [3:0] c, input string n);
        sb.push_back({r, b, d, c});
        sb_name.push_back(n);
    endtask

    task automatic drive_nop();
        ID_EX_A = '0; ID_EX_B = '0; ID_EX_rt = '0; ID_EX_rs = '0; ID_EX_rd = '0;
        ID_EX_opcode = '0; ID_EX_sign_extend_offset = '0;
        ID_EX_wb_reg_write = 0; ID_EX_wb_mem_to_reg = 0; ID_EX_mem_read = 0; ID_EX_mem_write = 0;
        ID_EX_ex_imm_command = 0; ID_EX_ex_alu_src_b = 0; ID_EX_ex_alu_rslt_src = 0;
        ID_EX_ex_dst_reg_sel = 2'b00; ID_EX_ex_alu_op = 2'b00;
    endtask

    task automatic drive_r(input logic [31:0] a, input logic [31:0] b, input logic [5:0] funct,
                           input logic [4:0] shamt, input logic [4:0] rd);
        drive_nop();
        ID_EX_A = a; ID_EX_B = b; ID_EX_rt = 5'd1; ID_EX_rd = rd;
        ID_EX_sign_extend_offset = {16'h0000, 5'd0, shamt, funct};
        ID_EX_wb_reg_write = 1; ID_EX_ex_dst_reg_sel = 2'b01; ID_EX_ex_alu_op = 2'b10;
    endtask

    task automatic drive_i(input logic [5:0] op, input logic [1:0] alu_op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] off, input logic imm_cmd,
                           input logic [4:0] rt);
        drive_nop();
        ID_EX_A = a; ID_EX_B = b; ID_EX_rt = rt; ID_EX_rd = 5'd30; ID_EX_opcode = op;
        ID_EX_sign_extend_offset = off; ID_EX_ex_imm_command = imm_cmd;
        ID_EX_ex_alu_src_b = 1; ID_EX_wb_reg_write = 1; ID_EX_ex_alu_op = alu_op;
    endtask

    task automatic drive_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        drive_nop();
        ID_EX_A = a; ID_EX_B = b; ID_EX_rd = rd; ID_EX_rt = 5'd2;
        ID_EX_ex_alu_rslt_src = 1; ID_EX_wb_reg_write = 1; ID_EX_ex_dst_reg_sel = 2'b01;
    endtask

    task automatic test_reset();
        exmem_t got;
        rst_n = 0; rst_n4 = 0;
        drive_mul(32'd7, 32'd9, 5'd4);
        #1;
        got = exmem1();
        checks++;
        if (got !== '0) begin
            errors++; $display("[TB] FAIL reset_exmem got %h required 0", got);
        end
        checks++;
        if (pstop_o !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_pstop got %b required 0", pstop_o);
        end
        checks++;
        if (ex_dst_reg !== 5'd4) begin
            errors++; $display("[TB] FAIL reset_dst_follows got %0d required 4", ex_dst_reg);
        end
        step(); step();
        drive_nop();
        rst_n = 1;
    endtask

    task automatic test_alu();
        logic [31:0] ta[11], tb_v[11], te[11];
        logic [5:0]  tf[11];
        logic [4:0]  ts[11];
        exmem_t exp, got;
        string nm;
        ta   = '{32'h7FFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0, 32'd5, 32'h0F0F0000,
                 32'h0, 32'h0, 32'hFFFF0000, 32'd3, 32'hFFFFFFFF};
        tb_v = '{32'd1, 32'd3, 32'd3, 32'h80000000, 32'd7, 32'h00FF00FF,
                 32'h80000000, 32'd1, 32'h0F0F0F0F, 32'd4, 32'd2};
        tf   = '{6'h20, 6'h2A, 6'h2B, 6'h03, 6'h22, 6'h27, 6'h02, 6'h00, 6'h26, 6'h18, 6'h21};
        ts   = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0};
        te   = '{32'h80000000, 32'd1, 32'd0, 32'hF8000000, 32'hFFFFFFFE, 32'hF000FF00,
                 32'd1, 32'h80000000, 32'hF0F00F0F, 32'd0, 32'd1};
        for (int i = 0; i < 11; i++) begin
            drive_r(ta[i], tb_v[i], tf[i], ts[i], 5'd5);
            push_exp(te[i], tb_v[i], 5'd5, 4'b1000, $sformatf("alu_funct_%h", tf[i]));
            step();
            exp = sb.pop_front(); nm = sb_name.pop_front(); got = exmem1();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s got res=%h b=%h dst=%0d ctrl=%b required res=%h b=%h dst=%0d ctrl=%b",
                         nm, got.result, got.b, got.dst, got.ctrl, exp.result, exp.b, exp.dst, exp.ctrl);
            end
        end
    endtask

    task automatic test_immediates();
        logic [5:0]  op[9];
        logic [1:0]  aop[9];
        logic [31:0] ta[9], toff[9], te[9];
        logic        ic[9];
        exmem_t exp, got;
        string nm;
        op   = '{6'h0D, 6'h0F, 6'h0A, 6'h0B, 6'h0C, 6'h0E, 6'h08, 6'h00, 6'h08};
        aop  = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
        ta   = '{32'h12340000, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFFF,
                 32'h0000FFFF, 32'd10, 32'h100, 32'h12345678};
        toff = '{32'hFFFF8001, 32'hFFFFABCD, 32'hFFFFFFFF, 32'h10, 32'hFFFF8F0F,
                 32'h0000F0F0, 32'hFFFFFFFF, 32'h10, 32'h1};
        ic   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        te   = '{32'h12348001, 32'hABCD0000, 32'd1, 32'd0, 32'h00008F0F,
                 32'h00000F0F, 32'd9, 32'hF0, 32'd0};
        for (int i = 0; i < 9; i++) begin
            drive_i(op[i], aop[i], ta[i], 32'h5555AAAA, toff[i], ic[i], 5'd8);
            push_exp(te[i], 32'h5555AAAA, 5'd8, 4'b1000, $sformatf("imm_op_%h_aluop_%b", op[i], aop[i]));
            step();
            exp = sb.pop_front(); nm = sb_name.pop_front(); got = exmem1();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s got res=%h b=%h dst=%0d ctrl=%b required res=%h b=%h dst=%0d ctrl=%b",
                         nm, got.result, got.b, got.dst, got.ctrl, exp.result, exp.b, exp.dst, exp.ctrl);
            end
        end
    endtask

    task automatic test_store_load();
        exmem_t exp, got;
        string nm;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                drive_i(6'h2B, 2'b00, 32'h100, 32'hDEADBEEF, 32'hFFFFFFFC, 1'b0, 5'd9);
                ID_EX_wb_reg_write = 0; ID_EX_mem_write = 1;
                push_exp(32'hFC, 32'hDEADBEEF, 5'd9, 4'b0001, "store_sw");
            end else begin
                drive_i(6'h23, 2'b00, 32'h200, 32'h0, 32'h4, 1'b0, 5'd10);
                ID_EX_wb_mem_to_reg = 1; ID_EX_mem_read = 1;
                push_exp(32'h204, 32'h0, 5'd10, 4'b1110, "load_lw");
            end
            step();
            exp = sb.pop_front(); nm = sb_name.pop_front(); got = exmem1();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s got res=%h b=%h dst=%0d ctrl=%b required res=%h b=%h dst=%0d ctrl=%b",
                         nm, got.result, got.b, got.dst, got.ctrl, exp.result, exp.b, exp.dst, exp.ctrl);
            end
        end
    endtask

    task automatic test_dst_sel();
        logic [4:0] want[4];
        want = '{5'd3, 5'd17, 5'd31, 5'd0};
        drive_nop();
        ID_EX_rt = 5'd3; ID_EX_rd = 5'd17;
        for (int s = 0; s < 4; s++) begin
            ID_EX_ex_dst_reg_sel = 2'(s);
            #1;
            checks++;
            if (ex_dst_reg !== want[s]) begin
                errors++; $display("[TB] FAIL dst_sel_%0d got %0d required %0d", s, ex_dst_reg, want[s]);
            end
        end
        drive_nop();
    endtask

    // Two multiplies issued back to back on the one-bit-per-step instance.
    task automatic test_multiply();
        logic [31:0] ma[2], mb[2], mp[2];
        int stalls, bubbles;
        exmem_t exp, got;
        string nm;
        ma = '{32'd7, 32'h12345678};
        mb = '{32'hFFFFFFFD, 32'h10};
        mp = '{32'hFFFFFFEB, 32'h23456780};
        for (int k = 0; k < 2; k++) begin
            drive_mul(ma[k], mb[k], 5'(12 + k));
            push_exp(mp[k], mb[k], 5'(12 + k), 4'b1000, $sformatf("mul_product_%0d", k));
            #1;
            stalls = 0; bubbles = 0;
            while (pstop_o === 1'b1 && stalls < 100) begin
                stalls++;
                step();
                if (exmem1().ctrl === 4'b0000) bubbles++;
            end
            checks++;
            if (stalls != 33) begin
                errors++; $display("[TB] FAIL mul_stall_cycles_%0d got %0d required 33", k, stalls);
            end
            checks++;
            if (bubbles != 33) begin
                errors++; $display("[TB] FAIL mul_bubbles_%0d got %0d required 33", k, bubbles);
            end
            step();
            exp = sb.pop_front(); nm = sb_name.pop_front(); got = exmem1();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s got res=%h b=%h dst=%0d ctrl=%b required res=%h b=%h dst=%0d ctrl=%b",
                         nm, got.result, got.b, got.dst, got.ctrl, exp.result, exp.b, exp.dst, exp.ctrl);
            end
        end
        drive_nop();
    endtask

    task automatic test_multiply_bps4();
        int stalls;
        exmem_t exp, got;
        string nm;
        rst_n = 0; rst_n4 = 1;
        drive_mul(32'd7, 32'hFFFFFFFD, 5'd20);
        push_exp(32'hFFFFFFEB, 32'hFFFFFFFD, 5'd20, 4'b1000, "mul4_product");
        #1;
        stalls = 0;
        while (pstop4 === 1'b1 && stalls < 100) begin
            stalls++;
            step();
        end
        checks++;
        if (stalls != 9) begin
            errors++; $display("[TB] FAIL mul4_stall_cycles got %0d required 9", stalls);
        end
        step();
        exp = sb.pop_front(); nm = sb_name.pop_front(); got = exmem4();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got res=%h b=%h dst=%0d ctrl=%b required res=%h b=%h dst=%0d ctrl=%b",
                     nm, got.result, got.b, got.dst, got.ctrl, exp.result, exp.b, exp.dst, exp.ctrl);
        end
        drive_nop();
        rst_n4 = 0; rst_n = 1;
    endtask

    task automatic test_reset_busy();
        exmem_t exp, got;
        string nm;
        drive_r(32'h11110000, 32'h00002222, 6'h20, 5'd0, 5'd6);
        push_exp(32'h11112222, 32'h00002222, 5'd6, 4'b1000, "pre_reset_add");
        step();
        exp = sb.pop_front(); nm = sb_name.pop_front(); got = exmem1();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got res=%h dst=%0d ctrl=%b required res=%h dst=%0d ctrl=%b",
                     nm, got.result, got.dst, got.ctrl, exp.result, exp.dst, exp.ctrl);
        end
        drive_mul(32'd3, 32'd5, 5'd7);
        for (int i = 0; i < 11; i++) step();
        #2;
        checks++;
        if (pstop_o !== 1'b1) begin
            errors++; $display("[TB] FAIL busy_pstop_before_reset got %b required 1", pstop_o);
        end
        rst_n = 0;
        #1;
        got = exmem1();
        checks++;
        if (got !== '0) begin
            errors++; $display("[TB] FAIL busy_reset_exmem got %h required 0", got);
        end
        checks++;
        if (pstop_o !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_reset_pstop got %b required 0", pstop_o);
        end
        step();
        drive_r(32'd2, 32'd3, 6'h20, 5'd0, 5'd6);
        rst_n = 1;
        push_exp(32'd5, 32'd3, 5'd6, 4'b1000, "post_reset_add");
        step();
        exp = sb.pop_front(); nm = sb_name.pop_front(); got = exmem1();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got res=%h dst=%0d ctrl=%b required res=%h dst=%0d ctrl=%b",
                     nm, got.result, got.dst, got.ctrl, exp.result, exp.dst, exp.ctrl);
        end
        drive_nop();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the bench completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_immediates();
        test_store_load();
        test_dst_sel();
        test_multiply();
        test_multiply_bps4();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute pipeline stage of the 5-stage MIPS core. It consumes the ID/EX pipeline register and computes ALU, shift and immediate results. An iterative multiplier stalls the front of the pipeline while it runs. Results and control are registered into the EX/MEM pipeline register, whose result also feeds the ID-stage forwarding mux as `mem_fwd_val`.

## Interface
- `BITS_PER_STEP`, default 1: multiplier bits retired per BUSY cycle; legal values 1, 2, 4. BUSY length N = 32/BITS_PER_STEP.
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ID_EX_A`, `ID_EX_B` in 32: forwarded rs and rt operands.
- `ID_EX_rt`, `ID_EX_rs`, `ID_EX_rd` in 5: register numbers.
- `ID_EX_opcode` in 6: instruction opcode.
- `ID_EX_sign_extend_offset` in 32: sign-extended imm16; [5:0] funct, [10:6] shamt.
- `ID_EX_wb_reg_write`, `ID_EX_wb_mem_to_reg`, `ID_EX_mem_read`, `ID_EX_mem_write` in 1: passthrough control.
- `ID_EX_ex_imm_command`, `ID_EX_ex_alu_src_b`, `ID_EX_ex_alu_rslt_src` in 1: EX control.
- `ID_EX_ex_dst_reg_sel`, `ID_EX_ex_alu_op` in 2: EX control.
- `EX_MEM_alu_result` out 32: registered result or address.
- `EX_MEM_B` out 32: registered store data (= `ID_EX_B`).
- `EX_MEM_dst_reg` out 5: registered destination register.
- `EX_MEM_wb_reg_write`, `EX_MEM_wb_mem_to_reg`, `EX_MEM_mem_read`, `EX_MEM_mem_write` out 1: registered control.
- `ex_dst_reg` out 5: combinational destination, for the hazard/forwarding unit.
- `pstop_o` out 1: combinational stall request; drives `pstop_i` of the IF and ID stages.

## Operation
- Operand B: `ID_EX_B` when `ex_alu_src_b`=0, otherwise the immediate. The immediate is `ID_EX_sign_extend_offset`, or `{16'b0, offset[15:0]}` when `ex_imm_command`=1.
- `ex_alu_op` 00 (add): used for lw/sw/addi/addiu; result A+Bop.
- `ex_alu_op` 01 (sub): result A−Bop.
- `ex_alu_op` 10 (R-type, by funct):
  - 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
  - 0x2A slt (signed), 0x2B sltu.
  - 0x00 sll, 0x02 srl, 0x03 sra: operate on B by shamt.
  - Any other funct gives result 0.
- `ex_alu_op` 11 (immediate, by opcode): 0x0A slti, 0x0B sltiu, 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui ({imm16,16'b0}). Any other opcode gives 0.
- All arithmetic wraps modulo 2^32; no overflow trap.
- `ex_dst_reg`: `ex_dst_reg_sel` 00 → rt, 01 → rd, 10 → 31, 11 → 0.
- Multiply:
  - A multiply instruction is `ex_alu_rslt_src`=1 && `wb_reg_write`=1.
  - Result is the low 32 bits of A×B (identical for signed and unsigned), written to `ex_dst_reg`.
- FSM states:
  - IDLE: if a multiply is present, latch mcand=A, mplier=B, acc=0, cnt=0 and go to BUSY.
  - BUSY: each cycle, acc += mcand×mplier[BITS_PER_STEP-1:0]; mcand <<= BITS_PER_STEP; mplier >>= BITS_PER_STEP; cnt++. When cnt=N−1, go to DONE.
  - DONE: the product is the result; go to IDLE.
- `pstop_o` = multiply present && state≠DONE; forced 0 while `rst_n`=0.
- EX/MEM update rule:
  - When `pstop_o`=1, capture a bubble: all four control outputs 0, data fields don't-care but held.
  - Otherwise capture the computed result and control.
  - When `ex_alu_rslt_src`=1, the result is acc. When it is 0, the result is the ALU value.

## Timing
- ALU ops: 1-cycle latency; EX/MEM is valid at the edge after the op appears in ID/EX.
- Multiply in ID/EX at cycle 0:
  - `pstop_o`=1 in cycles 0..N.
  - DONE occurs in cycle N+1 with `pstop_o`=0.
  - Product is captured at the end of cycle N+1.
  - EX/MEM carries bubbles for cycles 1..N+1 (N+1 bubbles).
- Upstream must hold ID/EX stable while `pstop_o`=1. EX assumes this and does not re-latch operands in BUSY.
- Back-to-back multiplies: DONE→IDLE, and the next multiply starts in the following cycle with no extra gap.
- Reset values: all EX/MEM outputs 0, FSM IDLE, acc/cnt 0, `pstop_o`=0. `ex_dst_reg` follows its inputs.
- Reset asserted mid-BUSY: the FSM aborts to IDLE immediately and no partial product is ever written.

## Test plan
- Add: A=0x7FFFFFFF, B=1, alu_op=10, funct 0x20, dst_sel=01, rd=5 → next edge: result 0x80000000, dst 5, reg_write 1.
- Compare and shift: A=0xFFFFFFFE, B=3 → slt gives 1 and sltu gives 0. sra with B=0x80000000, shamt 4 → 0xF8000000.
- Immediates: ori with A=0x12340000, imm 0x8001, imm_command=1 → 0x12348001. lui with imm 0xABCD → 0xABCD0000.
- Store: sw with A=0x100, offset 0xFFFFFFFC, B=0xDEADBEEF → result 0xFC, EX_MEM_B 0xDEADBEEF, mem_write 1.
- Multiply 7×0xFFFFFFFD (BITS_PER_STEP=1):
  - `pstop_o` high for 33 cycles.
  - 33 bubbles reach EX/MEM.
  - Result 0xFFFFFFEB lands on the 34th edge.
  - Repeat with BITS_PER_STEP=4: 9 stall cycles.
- Reset during BUSY at cnt=10 → outputs 0 and `pstop_o` 0 asynchronously. After release, an ALU op completes normally.
